// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// EX branch flushes and multi-cycle multiply occupancy. Optional PIPE_HAZARD_PERF_EN adds a stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  idex_memread_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_uses_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  ex_mul_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_write_o,
  output logic                  idex_flush_o,
  output logic                  exmem_write_o,
  output logic                  exmem_flush_o,
  output logic                  memwb_write_o,
  output logic                  busy_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lu;
  logic [7:0]       w_ctl;

  // Load-use detection; a load to $zero never creates a dependency
  always_comb begin
    w_lu = idex_memread_i
         & (idex_rt_i != {REG_ADDR_W{1'b0}})
         & ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));
  end

  // Control vector {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w}
  always_comb begin
    w_ctl = 8'b1101_0101;
    if (rst_i) begin
      w_ctl = 8'b0000_0000;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken_i) begin
            w_ctl = 8'b1010_1101;
          end else if (ex_mul_i) begin
            w_ctl = 8'b0000_0011;
          end else if (w_lu) begin
            w_ctl = 8'b0000_1101;
          end else begin
            w_ctl = 8'b1101_0101;
          end
        end
        MUL_BUSY: begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            w_ctl = 8'b0000_0011;
          end else begin
            w_ctl = 8'b1101_0101;
          end
        end
        default: w_ctl = 8'b0000_0000;
      endcase
    end
  end

  assign {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
          idex_flush_o, exmem_write_o, exmem_flush_o, memwb_write_o} = w_ctl;
  assign busy_o = (r_state == MUL_BUSY);

  // Multiply FSM: the RUN cycle that sees the multiply counts as its first EX cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        RUN: begin
          if (!branch_taken_i && ex_mul_i) begin
            r_state <= MUL_BUSY;
            r_cnt   <= CNT_W'(MUL_LAT - 2);
          end
        end
        MUL_BUSY: begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 16'h0000;
    end else if (!pc_write_o && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       idex_memread_i;
  logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic       ifid_uses_rt_i, branch_taken_i, ex_mul_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o;
  logic       exmem_write_o, exmem_flush_o, memwb_write_o, busy_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cnt_o;
`endif

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .ifid_uses_rt_i (ifid_uses_rt_i),
    .branch_taken_i (branch_taken_i),
    .ex_mul_i       (ex_mul_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_write_o   (idex_write_o),
    .idex_flush_o   (idex_flush_o),
    .exmem_write_o  (exmem_write_o),
    .exmem_flush_o  (exmem_flush_o),
    .memwb_write_o  (memwb_write_o),
    .busy_o         (busy_o)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  wire [8:0] w_obs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
                      exmem_write_o, exmem_flush_o, memwb_write_o, busy_o};

  int n_total = 0;
  int n_bad   = 0;

  // Model state: remaining cycles the multiply still spends in EX after its first one
  int mul_left = 0;
  int m_stall  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w, busy}
  function automatic logic [8:0] model_out(input logic rst, mr, input logic [4:0] irt, rs, rt,
                                           input logic urt, br, mul);
    logic lu;
    lu = mr && (irt != 5'd0) && ((irt == rs) || (urt && irt == rt));
    if (rst)              return 9'b0_0000_0000;
    if (mul_left > 1)     return 9'b0_0000_0111;
    if (mul_left == 1)    return 9'b1_1010_1011;
    if (br)               return 9'b1_0101_1010;
    if (mul)              return 9'b0_0000_0110;
    if (lu)               return 9'b0_0001_1010;
    return 9'b1_1010_1010;
  endfunction

  task automatic cyc(input logic rst, mr, input logic [4:0] irt, rs, rt,
                     input logic urt, br, mul);
    logic [8:0] exp;
    @(negedge clk);
    rst_i = rst; idex_memread_i = mr; idex_rt_i = irt; ifid_rs_i = rs; ifid_rt_i = rt;
    ifid_uses_rt_i = urt; branch_taken_i = br; ex_mul_i = mul;
    if (rst) begin
      mul_left = 0;
      m_stall  = 0;
    end
    #1;
    exp = model_out(rst, mr, irt, rs, rt, urt, br, mul);
    check("ctl", {23'd0, w_obs}, {23'd0, exp});
`ifdef PIPE_HAZARD_PERF_EN
    check("perf", {16'd0, stall_cnt_o}, m_stall);
`endif
    @(posedge clk);
    if (!rst) begin
      if (!exp[8] && m_stall < 65535) m_stall++;
      if (mul_left > 0) mul_left--;
      else if (!br && mul) mul_left = MUL_LAT - 1;
    end
  endtask

  initial begin
    rst_i = 1'b1; idex_memread_i = 1'b0; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
    ifid_uses_rt_i = 1'b0; branch_taken_i = 1'b0; ex_mul_i = 1'b0;

    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    // load-use on rs, then the bubble sits in ID/EX
    cyc(1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0);
    // $zero destination and unused rt do not stall; used rt does
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    // taken branch masks the load-use match
    cyc(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    // two back-to-back multiplies from a cleared counter
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * MUL_LAT; i++)
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    check("perf_two_mul", {16'd0, stall_cnt_o}, 32'd6);
`endif
    // reset while the multiply counter is at 1
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] kind;
      kind = 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          (kind == 3'd0), (kind == 3'd1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
